// File: rtl/mdio_master_ctrl_pkg.sv
// Shared constants, FSM state type and header builder for the Clause-22 MDIO master.
package mdio_master_ctrl_pkg;

  localparam logic [1:0]  MDIO_ST        = 2'b01;
  localparam logic [1:0]  MDIO_OP_RD     = 2'b10;
  localparam logic [1:0]  MDIO_OP_WR     = 2'b01;
  localparam int unsigned MDIO_HDR_BITS  = 14;
  localparam int unsigned MDIO_DATA_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_TA,
    ST_DATA,
    ST_END
  } mdio_state_t;

  function automatic logic [MDIO_HDR_BITS-1:0] mdio_header(input logic       rd,
                                                           input logic [4:0] phy,
                                                           input logic [4:0] rg);
    return {MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR), phy, rg};
  endfunction

endpackage

// File: rtl/mdio_master_ctrl_tick_gen.sv
// MDC generator: divides clk by CLK_DIV per half-period, flags the cycle before each MDC edge.
module mdc_tick_gen #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int unsigned     DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             wrap;

  assign wrap      = run && (div == DIV_LAST);
  assign fall_tick = wrap & mdc;
  assign rise_tick = wrap & ~mdc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      mdc <= 1'b0;
    end else if (clear) begin
      div <= '0;
      mdc <= 1'b0;
    end else if (run) begin
      if (wrap) begin
        div <= '0;
        mdc <= ~mdc;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// Clause-22 MDIO master: serialises one read/write frame per accepted command and
// returns read data plus a no-PHY flag sampled from the second turnaround bit.
module mdio_master_ctrl
  import mdio_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50,
  parameter int unsigned PRE_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam logic [5:0] PRE_LAST  = 6'(PRE_BITS - 1);
  localparam logic [5:0] HDR_LAST  = 6'(MDIO_HDR_BITS - 1);
  localparam logic [5:0] DATA_LAST = 6'(MDIO_DATA_BITS - 1);

  mdio_state_t                state, state_n;
  logic [5:0]                 cnt, cnt_n;
  logic [15:0]                shreg, shreg_n;
  logic [MDIO_HDR_BITS-1:0]   hdr, hdr_n;
  logic                       rd, rd_n;
  logic                       end_done, end_done_n;
  logic                       rsp_valid_n, rsp_err_n, mdio_o_n, mdio_t_n;
  logic [15:0]                rsp_rdata_n;
  logic                       fall_tick, rise_tick;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;

  // The divider is frozen for the single clk between the END fall edge and rsp_valid.
  mdc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .run       ((state != ST_IDLE) && !end_done),
    .clear     (state == ST_IDLE),
    .mdc       (mdc),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hdr       <= '0;
      rd        <= 1'b0;
      end_done  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      hdr       <= hdr_n;
      rd        <= rd_n;
      end_done  <= end_done_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      mdio_o    <= mdio_o_n;
      mdio_t    <= mdio_t_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    hdr_n       = hdr;
    rd_n        = rd;
    end_done_n  = end_done;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    mdio_o_n    = mdio_o;
    mdio_t_n    = mdio_t;

    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_n     = ST_PRE;
          cnt_n       = '0;
          hdr_n       = mdio_header(cmd_rd, cmd_phy_addr, cmd_reg_addr);
          rd_n        = cmd_rd;
          shreg_n     = cmd_rd ? '0 : cmd_wdata;
          rsp_rdata_n = '0;
          rsp_err_n   = 1'b0;
          mdio_o_n    = 1'b1;
          mdio_t_n    = 1'b0;
        end
      end

      ST_PRE: begin
        if (fall_tick) begin
          if (cnt == PRE_LAST) begin
            state_n  = ST_HDR;
            cnt_n    = '0;
            mdio_o_n = hdr[MDIO_HDR_BITS-1];
          end else begin
            cnt_n = cnt + 6'd1;
          end
        end
      end

      // Header and write data are launched from the MSB of a left-shifting register.
      ST_HDR: begin
        if (fall_tick) begin
          if (cnt == HDR_LAST) begin
            state_n  = ST_TA;
            cnt_n    = '0;
            mdio_o_n = 1'b1;
            mdio_t_n = rd;
          end else begin
            cnt_n    = cnt + 6'd1;
            hdr_n    = hdr << 1;
            mdio_o_n = hdr[MDIO_HDR_BITS-2];
          end
        end
      end

      ST_TA: begin
        if (rise_tick && rd && (cnt == 6'd1)) begin
          rsp_err_n = mdio_i;
        end
        if (fall_tick) begin
          if (cnt == 6'd1) begin
            state_n = ST_DATA;
            cnt_n   = '0;
            if (!rd) mdio_o_n = shreg[15];
          end else begin
            cnt_n = 6'd1;
            if (!rd) mdio_o_n = 1'b0;
          end
        end
      end

      ST_DATA: begin
        if (rise_tick && rd) begin
          shreg_n = {shreg[14:0], mdio_i};
        end
        if (fall_tick) begin
          if (cnt == DATA_LAST) begin
            state_n  = ST_END;
            cnt_n    = '0;
            mdio_o_n = 1'b1;
            mdio_t_n = 1'b1;
          end else begin
            cnt_n = cnt + 6'd1;
            if (!rd) begin
              shreg_n  = shreg << 1;
              mdio_o_n = shreg[14];
            end
          end
        end
      end

      ST_END: begin
        if (end_done) begin
          state_n     = ST_IDLE;
          end_done_n  = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = rd ? shreg : '0;
        end else if (fall_tick) begin
          end_done_n = 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Bench for mdio_master_ctrl: directed table, back-to-back, async abort and random frames,
// all checked against a frame-level model of the Clause-22 wire format.
module tb_mdio_master_ctrl;

  localparam int PRE = 32;

  typedef struct {
    logic        rd;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    bit          present;
    logic [15:0] pdata;
    bit          sel;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_rd = 1'b0;
  logic [4:0] cmd_phy_addr = '0;
  logic [4:0] cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic mdio_i = 1'b1;
  logic sel = 1'b0;

  logic v0, v1, r0, r1, rv0, rv1, er0, er1, b0, b1, mdc0, mdc1, o0, o1, t0, t1;
  logic [15:0] rd0, rd1;
  logic m_ready, m_rv, m_err, m_busy, m_mdc, m_o, m_t;
  logic [15:0] m_rdata;

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;

  assign v0 = cmd_valid & ~sel;
  assign v1 = cmd_valid & sel;
  assign m_ready = sel ? r1 : r0;
  assign m_rv    = sel ? rv1 : rv0;
  assign m_err   = sel ? er1 : er0;
  assign m_busy  = sel ? b1 : b0;
  assign m_mdc   = sel ? mdc1 : mdc0;
  assign m_o     = sel ? o1 : o0;
  assign m_t     = sel ? t1 : t0;
  assign m_rdata = sel ? rd1 : rd0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rv0) pulses0 <= pulses0 + 1;

  mdio_master_ctrl #(.CLK_DIV(4), .PRE_BITS(PRE)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(v0), .cmd_ready(r0), .cmd_rd(cmd_rd),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0), .busy(b0), .mdc(mdc0),
    .mdio_o(o0), .mdio_t(t0), .mdio_i(mdio_i)
  );

  mdio_master_ctrl #(.CLK_DIV(1), .PRE_BITS(PRE)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(r1), .cmd_rd(cmd_rd),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1), .busy(b1), .mdc(mdc1),
    .mdio_o(o1), .mdio_t(t1), .mdio_i(mdio_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Wire value expected in MDC period k: 0/1 driven, 2 released.
  function automatic int exp_bit(input vec_t v, input int k);
    logic [13:0] hdr;
    int j;
    hdr = {2'b01, (v.rd ? 2'b10 : 2'b01), v.phy, v.rg};
    if (k < PRE) return 1;
    j = k - PRE;
    if (j < 14) return int'(hdr[13-j]);
    j -= 14;
    if (j < 2) return v.rd ? 2 : ((j == 0) ? 1 : 0);
    j -= 2;
    if (j < 16) return v.rd ? 2 : int'(v.wd[15-j]);
    return 2;
  endfunction

  // What the PHY (or the pull-up) puts on the pin during MDC period k.
  function automatic logic phy_drive(input vec_t v, input int k);
    if (!v.rd || !v.present) return 1'b1;
    if (k == PRE + 15) return 1'b0;
    if (k >= PRE + 16 && k < PRE + 32) return v.pdata[15-(k-PRE-16)];
    return 1'b1;
  endfunction

  function automatic vec_t with_expect(input vec_t v);
    vec_t r;
    r = v;
    r.exp_rdata = v.rd ? (v.present ? v.pdata : 16'hFFFF) : 16'h0000;
    r.exp_err   = v.rd && !v.present;
    return r;
  endfunction

  task automatic start_cmd(input vec_t v, input bit hold);
    int w;
    sel = v.sel;
    cmd_rd = v.rd;
    cmd_phy_addr = v.phy;
    cmd_reg_addr = v.rg;
    cmd_wdata = v.wd;
    mdio_i = 1'b1;
    cmd_valid = 1'b1;
    w = 0;
    while (!m_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!m_ready) check("accept_wait", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Called one step after the accept edge; returns in the cycle rsp_valid is seen.
  task automatic run_frame(input vec_t v, input string name);
    int div, lat_exp, n, rises, bad, ready_bad, cap, lat;
    bit prev, got;
    div = v.sel ? 1 : 4;
    lat_exp = (PRE + 33) * 2 * div + 1;
    check({name, "_clear"}, 32'({m_rdata, m_err, m_busy}), 32'({16'h0000, 1'b0, 1'b1}));
    mdio_i = phy_drive(v, 0);
    prev = m_mdc;
    rises = 0; bad = 0; ready_bad = 0; got = 0; lat = 0; n = 0;
    while (!got && n < lat_exp + 40) begin
      @(posedge clk); #1;
      n++;
      if (m_mdc && !prev) begin
        cap = m_t ? 2 : int'(m_o);
        if (rises < 65 && cap != exp_bit(v, rises)) bad++;
        rises++;
      end
      if (!m_mdc && prev) mdio_i = phy_drive(v, rises);
      prev = m_mdc;
      if (m_rv) begin
        got = 1;
        lat = n;
      end else if (m_ready) begin
        ready_bad++;
      end
    end
    mdio_i = 1'b1;
    check({name, "_latency"}, 32'(lat), 32'(lat_exp));
    check({name, "_mdc_periods"}, 32'(rises), 32'd65);
    check({name, "_frame_bits"}, 32'(bad), 32'd0);
    check({name, "_ready_low"}, 32'(ready_bad), 32'd0);
    check({name, "_rsp"}, 32'({m_rdata, m_err}), 32'({v.exp_rdata, v.exp_err}));
    check({name, "_ready_with_rsp"}, 32'({m_ready, m_busy, m_mdc, m_t}), 32'b1001);
  endtask

  task automatic do_vec(input vec_t v, input string name);
    start_cmd(v, 0);
    run_frame(v, name);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_hold"}, 32'({m_rdata, m_err, m_rv}), 32'({v.exp_rdata, v.exp_err, 1'b0}));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t a, b, v;
    int p;

    vecs.push_back('{rd:1'b0, phy:5'd5,  rg:5'd0, wd:16'h1140, present:1'b0, pdata:16'h0000,
                     sel:1'b0, exp_rdata:16'h0000, exp_err:1'b0});
    vecs.push_back('{rd:1'b1, phy:5'd1,  rg:5'd2, wd:16'hDEAD, present:1'b1, pdata:16'h796D,
                     sel:1'b0, exp_rdata:16'h796D, exp_err:1'b0});
    vecs.push_back('{rd:1'b1, phy:5'd31, rg:5'd3, wd:16'h0000, present:1'b0, pdata:16'h0000,
                     sel:1'b0, exp_rdata:16'hFFFF, exp_err:1'b1});
    vecs.push_back('{rd:1'b1, phy:5'd7,  rg:5'd9, wd:16'h0000, present:1'b1, pdata:16'hA5C3,
                     sel:1'b1, exp_rdata:16'hA5C3, exp_err:1'b0});

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({r0, b0, rv0, rd0, er0, mdc0, o0, t0}),
          32'({1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1}));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", 32'({r0, b0, mdc0, t0, r1, b1, mdc1, t1}), 32'b10011001);

    for (int i = 0; i < vecs.size(); i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: second command held by the source during the first frame.
    a = vecs[0];
    b = vecs[1];
    p = pulses0;
    start_cmd(a, 1);
    cmd_rd = b.rd; cmd_phy_addr = b.phy; cmd_reg_addr = b.rg; cmd_wdata = b.wd;
    run_frame(a, "b2b_first");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_second_accept", 32'({m_busy, m_mdc, m_ready}), 32'b100);
    run_frame(b, "b2b_second");
    @(posedge clk); #1;
    check("b2b_pulses", 32'(pulses0 - p), 32'd2);

    // Asynchronous reset in the middle of the DATA field.
    start_cmd(vecs[0], 0);
    repeat (55 * 8) @(posedge clk);
    #3;
    check("abort_busy_before", 32'(m_busy), 32'd1);
    p = pulses0;
    reset = 1'b1;
    #1;
    check("abort_async", 32'({m_mdc, m_t, m_busy, m_ready, m_o}), 32'b01011);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(pulses0 - p), 32'd0);
    do_vec(vecs[0], "after_abort");

    for (int i = 0; i < 8; i++) begin
      v.rd      = 1'($urandom_range(0, 1));
      v.phy     = 5'($urandom);
      v.rg      = 5'($urandom);
      v.wd      = 16'($urandom);
      v.present = 1'($urandom_range(0, 1));
      v.pdata   = 16'($urandom);
      v.sel     = (i >= 5);
      v = with_expect(v);
      do_vec(v, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
